// File: rtl/mem_lane_ctrl.sv
// mem_lane_ctrl
//   Memory-side responder for the 4-bit byte-enable access code produced by
//   the load/store decoder. The attached data memory is word-wide and has no
//   byte strobes, so sub-word stores become a read-modify-write sequence.
//   Loads return the selected lane, zero- or sign-extended to 32 bits.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req/we/addr/wdata/be core request (sampled in IDLE only, when ready=1)
//   ready               high in IDLE
//   done/err            one-cycle completion pulse; err valid with done
//   rdata               last load result, held between loads
//   mem_req/mem_we      memory request (held until mem_ack), write flag
//   mem_addr            word address (addr[ADDR_W-1:2])
//   mem_wdata           full word to write
//   mem_rdata/mem_ack   read word and one-cycle acknowledge
//
// Build option
//   MEM_TIMEOUT_EN  when defined, a request left unacknowledged for TIMEOUT
//                   cycles is abandoned and completes with err=1. When not
//                   defined the controller waits for mem_ack indefinitely.
//
// be codes (lane = be[1:0])
//   1111 word | 00bb byte, zero-ext | 01bb half bb[1], zero-ext
//   10bb signed byte (load only) | 11b0 signed half (load only) | 1101 illegal

module mem_lane_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [15:0]       sdata_q, sdata_d;     // sub-word store data; word stores go straight to mem_wdata
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              ack_hit;
    logic              timeout_hit;
    logic              illegal;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // The lane is carried by be, so the low address bits are deliberately dropped.
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];

    // An ack only counts while our request is actually on the bus, which
    // also makes stray acks in IDLE/RESP harmless.
    assign ack_hit = mem_req_q & mem_ack;

    // Stores may only use the word code or the zero-extended 0xxx codes;
    // 1101 is illegal for both directions.
    always_comb begin
        illegal = 1'b0;
        if (be == 4'b1101)
            illegal = 1'b1;
        else if (we && be[3] && (be != 4'b1111))
            illegal = 1'b1;
    end

    // ---------------------------------------------------------------
    // Lane extraction for loads
    // ---------------------------------------------------------------
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (be_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
    end

    assign half_sel = be_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_val = mem_rdata;
        if (be_q != 4'b1111) begin
            if (be_q[2])
                load_val = {{16{be_q[3] & half_sel[15]}}, half_sel};
            else
                load_val = {{24{be_q[3] & byte_sel[7]}}, byte_sel};
        end
    end

    // ---------------------------------------------------------------
    // Merge for sub-word stores: only the addressed lane(s) change
    // ---------------------------------------------------------------
    always_comb begin
        merged = mem_rdata;
        if (be_q[2]) begin
            if (be_q[1])
                merged[31:16] = sdata_q;
            else
                merged[15:0]  = sdata_q;
        end else begin
            case (be_q[1:0])
                2'd0: merged[7:0]   = sdata_q[7:0];
                2'd1: merged[15:8]  = sdata_q[7:0];
                2'd2: merged[23:16] = sdata_q[7:0];
                2'd3: merged[31:24] = sdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Optional request timeout
    // ---------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Fires on the TIMEOUT-th consecutive unacknowledged request cycle.
    assign timeout_hit = mem_req_q & ~mem_ack & (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        // Cleared on every state change, so each READ/WRITE entry starts at 0.
        if ((state_q == state_d) && ((state_q == S_READ) || (state_q == S_WRITE))) begin
            tmo_d = tmo_q;
            if (mem_req_q && !mem_ack)
                tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Next-state and datapath updates
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        sdata_d     = sdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d       = we;
                    be_d       = be;
                    sdata_d    = wdata[15:0];
                    mem_addr_d = addr[ADDR_W-1:2];
                    err_d      = illegal;
                    if (illegal) begin
                        state_d = S_RESP;
                    end else if (we && (be == 4'b1111)) begin
                        mem_wdata_d = wdata;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (ack_hit) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        state_d     = S_WRITE;
                    end else begin
                        rdata_d = load_val;
                        state_d = S_RESP;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                if (ack_hit) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The request is registered: it rises the cycle after entering READ/WRITE
    // and falls the cycle after the ack, which guarantees an idle bus cycle
    // between the read and write halves of a read-modify-write.
    always_comb begin
        mem_req_d = 1'b0;
        if ((state_q == S_READ) || (state_q == S_WRITE))
            mem_req_d = ~ack_hit & ~timeout_hit;
        mem_we_d = mem_req_d & (state_q == S_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            be_q        <= 4'b0;
            sdata_q     <= 16'h0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            sdata_q     <= sdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = done & err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
